// File: rtl/adder_421_pipe.sv
// Pipelined four-operand signed adder/subtractor: S = A +/- B +/- C +/- D (mod 2^IN_WIDTH).
// Carries ripple between STAGE_WIDTH-bit chunks through one register per chunk, so
// chunk k is computed k cycles after chunk 0. Optional skewed input/output modes let
// instances cascade without deskew/reskew registers in between.
module adder_421_pipe #(
   parameter int IN_WIDTH    = 256,
   parameter int STAGE_WIDTH = 64,
   parameter bit SUB_B       = 1'b0,
   parameter bit SUB_C       = 1'b0,
   parameter bit SUB_D       = 1'b0,
   parameter bit REG_IN_CAS  = 1'b0,
   parameter bit REG_OUT_CAS = 1'b0
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                in_valid,
   input  logic [IN_WIDTH-1:0] A,
   input  logic [IN_WIDTH-1:0] B,
   input  logic [IN_WIDTH-1:0] C,
   input  logic [IN_WIDTH-1:0] D,
   output logic [IN_WIDTH-1:0] S,
   output logic                out_valid
);

   localparam int NUM_CHUNKS = (IN_WIDTH + STAGE_WIDTH - 1) / STAGE_WIDTH;
   localparam int LAST_W     = IN_WIDTH - (NUM_CHUNKS - 1) * STAGE_WIDTH;
   // Two's complement negation is ~x + 1; the "+1" of every subtracted operand is
   // gathered into the carry-in of chunk 0.
   localparam int SUB_COUNT  = int'(SUB_B) + int'(SUB_C) + int'(SUB_D);
   // out_valid follows output chunk 0: 1 cycle when left skewed, N when deskewed.
   localparam int OV_LAT     = REG_OUT_CAS ? 1 : NUM_CHUNKS;

   logic [IN_WIDTH-1:0]     b_eff;
   logic [IN_WIDTH-1:0]     c_eff;
   logic [IN_WIDTH-1:0]     d_eff;
   // Slot k holds the carry into chunk k (slot 0 is the constant subtract correction).
   logic [2*NUM_CHUNKS-1:0] carry_bus;
   logic [OV_LAT-1:0]       valid_pipe;

   assign b_eff = SUB_B ? ~B : B;
   assign c_eff = SUB_C ? ~C : C;
   assign d_eff = SUB_D ? ~D : D;

   assign carry_bus[1:0] = 2'(SUB_COUNT);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
         localparam int CW      = (gi == NUM_CHUNKS - 1) ? LAST_W : STAGE_WIDTH;
         localparam int LO      = gi * STAGE_WIDTH;
         // The top chunk drops its carry-out, so it only needs a CW-bit sum.
         localparam int SW      = (gi == NUM_CHUNKS - 1) ? CW : CW + 2;
         localparam int IN_DLY  = REG_IN_CAS ? 0 : gi;
         localparam int OUT_DLY = REG_OUT_CAS ? 0 : NUM_CHUNKS - 1 - gi;

         logic [4*CW-1:0] opd_in;
         logic [4*CW-1:0] opd_skew;
         logic [1:0]      carry_in;
         logic [SW-1:0]   sum_full;
         logic [CW-1:0]   sum_reg;

         assign opd_in   = {d_eff[LO +: CW], c_eff[LO +: CW], b_eff[LO +: CW], A[LO +: CW]};
         assign carry_in = carry_bus[2*gi +: 2];

         if (IN_DLY > 0) begin : g_in_skew
            logic [4*CW-1:0] skew_reg [0:IN_DLY-1];

            // Delay this chunk's operands by its index so they meet the carry from below.
            always_ff @(posedge clk) begin
               if (!resetn) begin
                  for (int i = 0; i < IN_DLY; i++) skew_reg[i] <= '0;
               end else begin
                  skew_reg[0] <= opd_in;
                  for (int i = 1; i < IN_DLY; i++) skew_reg[i] <= skew_reg[i-1];
               end
            end

            assign opd_skew = skew_reg[IN_DLY-1];
         end else begin : g_in_direct
            assign opd_skew = opd_in;
         end

         // Four slices plus the incoming carry (0..3); the sum fits in CW+2 bits.
         always_comb begin
            sum_full = SW'(opd_skew[0 +: CW]) + SW'(opd_skew[CW +: CW])
                     + SW'(opd_skew[2*CW +: CW]) + SW'(opd_skew[3*CW +: CW])
                     + SW'(carry_in);
         end

         // Register this chunk's sum bits.
         always_ff @(posedge clk) begin
            if (!resetn) sum_reg <= '0;
            else         sum_reg <= sum_full[CW-1:0];
         end

         if (gi < NUM_CHUNKS - 1) begin : g_carry
            logic [1:0] carry_reg;

            // Register the carry out alongside the sum; it feeds chunk gi+1 next cycle.
            always_ff @(posedge clk) begin
               if (!resetn) carry_reg <= 2'b00;
               else         carry_reg <= sum_full[CW+1:CW];
            end

            assign carry_bus[2*(gi+1) +: 2] = carry_reg;
         end

         if (OUT_DLY > 0) begin : g_out_deskew
            logic [CW-1:0] deskew_reg [0:OUT_DLY-1];

            // Hold early chunks back so every chunk of S lands in the same cycle.
            always_ff @(posedge clk) begin
               if (!resetn) begin
                  for (int i = 0; i < OUT_DLY; i++) deskew_reg[i] <= '0;
               end else begin
                  deskew_reg[0] <= sum_reg;
                  for (int i = 1; i < OUT_DLY; i++) deskew_reg[i] <= deskew_reg[i-1];
               end
            end

            assign S[LO +: CW] = deskew_reg[OUT_DLY-1];
         end else begin : g_out_direct
            assign S[LO +: CW] = sum_reg;
         end
      end
   endgenerate

   // Delay in_valid to line up with output chunk 0.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_pipe <= '0;
      end else begin
         valid_pipe[0] <= in_valid;
         for (int i = 1; i < OV_LAT; i++) valid_pipe[i] <= valid_pipe[i-1];
      end
   end

   assign out_valid = valid_pipe[OV_LAT-1];

endmodule

// File: tb/tb_adder_421_pipe.sv
// Scoreboard bench for adder_421_pipe: standalone add, standalone subtract, a 254-bit
// instance with a short top chunk, and a four-into-one skewed cascade, all fed the
// same operand stream. Expected results are queued at issue time and popped by one
// monitor per instance whenever that instance raises out_valid.
module tb_adder_421_pipe;

   typedef struct {
      logic [255:0] v;
      int           c;
   } exp_t;

   logic         clk = 1'b0;
   logic         resetn;
   logic         in_valid;
   logic [255:0] a, b, c, d;

   logic [255:0] s_add, s_sub, s_cas;
   logic [253:0] s_254, su0, su1, su2, su3;
   logic         ov_add, ov_sub, ov_254, ov_cas, ou0, ou1, ou2, ou3;

   exp_t q_add[$], q_sub[$], q_254[$], q_cas[$];
   exp_t e_add, e_sub, e_254, e_cas;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adder_421_pipe #(.IN_WIDTH(256), .STAGE_WIDTH(64), .SUB_B(0), .SUB_C(0), .SUB_D(0),
                    .REG_IN_CAS(0), .REG_OUT_CAS(0)) dut_add (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .A(a), .B(b), .C(c), .D(d),
      .S(s_add), .out_valid(ov_add));

   adder_421_pipe #(.IN_WIDTH(256), .STAGE_WIDTH(64), .SUB_B(1), .SUB_C(1), .SUB_D(1),
                    .REG_IN_CAS(0), .REG_OUT_CAS(0)) dut_sub (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .A(a), .B(b), .C(c), .D(d),
      .S(s_sub), .out_valid(ov_sub));

   adder_421_pipe #(.IN_WIDTH(254), .STAGE_WIDTH(64), .SUB_B(1), .SUB_C(0), .SUB_D(1),
                    .REG_IN_CAS(0), .REG_OUT_CAS(0)) dut_254 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid),
      .A(a[253:0]), .B(b[253:0]), .C(c[253:0]), .D(d[253:0]),
      .S(s_254), .out_valid(ov_254));

   adder_421_pipe #(.IN_WIDTH(254), .STAGE_WIDTH(64), .SUB_B(0), .SUB_C(1), .SUB_D(1),
                    .REG_IN_CAS(0), .REG_OUT_CAS(1)) up0 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid),
      .A(a[253:0]), .B(b[253:0]), .C(c[253:0]), .D(d[253:0]), .S(su0), .out_valid(ou0));

   adder_421_pipe #(.IN_WIDTH(254), .STAGE_WIDTH(64), .SUB_B(1), .SUB_C(1), .SUB_D(0),
                    .REG_IN_CAS(0), .REG_OUT_CAS(1)) up1 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid),
      .A(a[253:0]), .B(b[253:0]), .C(c[253:0]), .D(d[253:0]), .S(su1), .out_valid(ou1));

   adder_421_pipe #(.IN_WIDTH(254), .STAGE_WIDTH(64), .SUB_B(1), .SUB_C(0), .SUB_D(1),
                    .REG_IN_CAS(0), .REG_OUT_CAS(1)) up2 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid),
      .A(a[253:0]), .B(b[253:0]), .C(c[253:0]), .D(d[253:0]), .S(su2), .out_valid(ou2));

   adder_421_pipe #(.IN_WIDTH(254), .STAGE_WIDTH(64), .SUB_B(1), .SUB_C(1), .SUB_D(1),
                    .REG_IN_CAS(0), .REG_OUT_CAS(1)) up3 (
      .clk(clk), .resetn(resetn), .in_valid(in_valid),
      .A(a[253:0]), .B(b[253:0]), .C(c[253:0]), .D(d[253:0]), .S(su3), .out_valid(ou3));

   adder_421_pipe #(.IN_WIDTH(256), .STAGE_WIDTH(64), .SUB_B(0), .SUB_C(0), .SUB_D(0),
                    .REG_IN_CAS(1), .REG_OUT_CAS(0)) down (
      .clk(clk), .resetn(resetn), .in_valid(ou0),
      .A({{2{su0[253]}}, su0}), .B({{2{su1[253]}}, su1}),
      .C({{2{su2[253]}}, su2}), .D({{2{su3[253]}}, su3}),
      .S(s_cas), .out_valid(ov_cas));

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // 254-bit signed result of x +/- y +/- z +/- w, sign-extended to 256 bits.
   function automatic logic [255:0] up_model(input logic [255:0] x, y, z, w,
                                             input bit sb, sc, sd);
      logic [255:0] t;
      t = x + (sb ? -y : y) + (sc ? -z : z) + (sd ? -w : w);
      return {{2{t[253]}}, t[253:0]};
   endfunction

   task automatic issue(input logic [255:0] ia, ib, ic, id, ea, es);
      logic [255:0] ecas;
      a = ia; b = ib; c = ic; d = id;
      in_valid = 1'b1;
      ecas = up_model(ia, ib, ic, id, 0, 1, 1) + up_model(ia, ib, ic, id, 1, 1, 0)
           + up_model(ia, ib, ic, id, 1, 0, 1) + up_model(ia, ib, ic, id, 1, 1, 1);
      q_add.push_back('{ea, cyc});
      q_sub.push_back('{es, cyc});
      q_254.push_back('{up_model(ia, ib, ic, id, 1, 0, 1), cyc});
      q_cas.push_back('{ecas, cyc});
   endtask

   function automatic logic [255:0] rnd252();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      r[255:252] = {4{r[251]}};
      return r;
   endfunction

   // Monitors: one per instance, popping on out_valid.
   always @(negedge clk) if (ov_add) begin
      if (q_add.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL add_valid: out_valid=1 at cycle %0d, required 0 (nothing pending)", cyc);
      end else begin
         e_add = q_add.pop_front();
         check("add_sum", s_add, e_add.v);
         check("add_latency", 256'(cyc - e_add.c), 256'(4));
         $display("add: cycle %0d S=%h", cyc, s_add);
      end
   end

   always @(negedge clk) if (ov_sub) begin
      if (q_sub.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL sub_valid: out_valid=1 at cycle %0d, required 0 (nothing pending)", cyc);
      end else begin
         e_sub = q_sub.pop_front();
         check("sub_diff", s_sub, e_sub.v);
         check("sub_latency", 256'(cyc - e_sub.c), 256'(4));
         $display("sub: cycle %0d S=%h", cyc, s_sub);
      end
   end

   always @(negedge clk) if (ov_254) begin
      if (q_254.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL w254_valid: out_valid=1 at cycle %0d, required 0 (nothing pending)", cyc);
      end else begin
         e_254 = q_254.pop_front();
         check("w254_sum", {2'b00, s_254}, {2'b00, e_254.v[253:0]});
         check("w254_latency", 256'(cyc - e_254.c), 256'(4));
         $display("w254: cycle %0d S=%h", cyc, s_254);
      end
   end

   always @(negedge clk) if (ov_cas) begin
      if (q_cas.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL cas_valid: out_valid=1 at cycle %0d, required 0 (nothing pending)", cyc);
      end else begin
         e_cas = q_cas.pop_front();
         check("cas_sum", s_cas, e_cas.v);
         check("cas_latency", 256'(cyc - e_cas.c), 256'(5));
         $display("cas: cycle %0d S=%h", cyc, s_cas);
      end
   end

   initial begin
      logic [255:0] one, ra, rb, rc, rd;
      one = 256'd1;

      // Reset held with nonzero, valid-flagged inputs.
      resetn = 1'b0; in_valid = 1'b1;
      a = '1; b = {64{4'hA}}; c = {64{4'h5}}; d = one;
      @(posedge clk);
      repeat (10) begin
         @(negedge clk);
         check("rst_add_S",  s_add, '0);
         check("rst_add_ov", {255'd0, ov_add}, '0);
         check("rst_cas_S",  s_cas, '0);
         check("rst_cas_ov", {255'd0, ov_cas}, '0);
      end
      resetn = 1'b1; in_valid = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      repeat (3) @(negedge clk);

      // Lone vector: carry out of chunk 0; out_valid must pulse exactly once.
      issue((one << 64) - one, one, '0, '0, one << 64, (one << 64) - 256'd2);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);

      // Directed vectors, back to back.
      issue('0, one, one, one, 256'd3, ~256'd2);
      @(negedge clk);
      issue('1, one << 255, one << 255, one << 255, (one << 255) - one, (one << 255) - one);
      @(negedge clk);
      issue('1, '1, '1, '1, ~256'd3, 256'd2);
      @(negedge clk);
      issue((one << 192) - one, one, '0, '0, one << 192, (one << 192) - 256'd2);
      @(negedge clk);
      issue(256'd5, 256'd7, 256'd11, 256'd13, 256'd36, ~256'd25);
      @(negedge clk);
      issue(one << 128, '0, '0, one, (one << 128) + one, (one << 128) - one);

      // 120 back-to-back vectors with 2 bits of sign-extension headroom.
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         ra = rnd252(); rb = rnd252(); rc = rnd252(); rd = rnd252();
         issue(ra, rb, rc, rd, ra + rb + rc + rd, ra - rb - rc - rd);
      end
      @(negedge clk);
      in_valid = 1'b0;

      // Bounded drain; anything still queued is a missing result.
      for (int i = 0; i < 60; i++) begin
         if (q_add.size() == 0 && q_sub.size() == 0 && q_254.size() == 0 && q_cas.size() == 0)
            break;
         @(negedge clk);
      end
      check("drain_add", 256'(q_add.size()), '0);
      check("drain_sub", 256'(q_sub.size()), '0);
      check("drain_w254", 256'(q_254.size()), '0);
      check("drain_cas", 256'(q_cas.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
